// File: rtl/product_reader_pkg.sv
// product_reader_pkg: shared state encoding, sizes and the decode-side rotate.
package product_reader_pkg;
  localparam int N_WORDS = 16;
  localparam int DATA_W = 8;
  localparam int KEY_W = 4;
  typedef enum logic [2:0] {IDLE, ADDR, READ, DIV, OUT} state_t;
  function automatic logic [KEY_W-1:0] rotr1(input logic [KEY_W-1:0] v);
    return {v[0], v[KEY_W-1:1]};
  endfunction
endpackage

// File: rtl/product_reader_seq_divider.sv
// seq_divider: 8-by-4 restoring divider, one quotient bit per cycle, MSB first.
module seq_divider
  import product_reader_pkg::*;
(
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic [DATA_W-1:0] dividend,
  input  logic [KEY_W-1:0]  divisor,
  output logic [DATA_W-1:0] quotient,
  output logic [KEY_W-1:0]  remainder,
  output logic              done
);
  logic [DATA_W-1:0] dvd, q;
  logic [KEY_W:0] rem, rem_sh;
  logic [2:0] cnt;
  logic run, ge;
  always_comb begin
    rem_sh = {rem[KEY_W-1:0], dvd[DATA_W-1]};
    ge = rem_sh >= {1'b0, divisor};
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      dvd <= '0;
      q <= '0;
      rem <= '0;
      cnt <= '0;
      run <= 1'b0;
    end else if (start) begin
      dvd <= dividend;
      q <= '0;
      rem <= '0;
      cnt <= '0;
      run <= 1'b1;
    end else if (run) begin
      dvd <= dvd << 1;
      q <= {q[DATA_W-2:0], ge};
      rem <= ge ? rem_sh - {1'b0, divisor} : rem_sh;
      cnt <= cnt + 3'd1;
      run <= cnt != 3'(DATA_W - 1);
    end
  end
  // done is asserted during the last step so the caller can leave its wait state on the same edge
  assign done = run && cnt == 3'(DATA_W - 1);
  assign quotient = q;
  assign remainder = rem[KEY_W-1:0];
endmodule

// File: rtl/product_reader.sv
// product_reader: scans all words, divides by key, un-rotates and streams checked results.
module product_reader
  import product_reader_pkg::*;
(
  input  logic               clk,
  input  logic               rst,
  input  logic               start,
  input  logic [KEY_W-1:0]   key,
  output logic               rd_en,
  output logic [N_WORDS-1:0] rd_addr,
  input  logic [DATA_W-1:0]  rd_data,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [KEY_W-1:0]   out_index,
  output logic [KEY_W-1:0]   out_num,
  output logic               out_err,
  output logic               busy,
  output logic               done,
  output logic               div0
);
  state_t state, nxt;
  logic [KEY_W-1:0] index, key_r, num;
  logic [DATA_W-1:0] q;
  logic [KEY_W-1:0] rem;
  logic div_done, accept, last;
  seq_divider u_div (
    .clk(clk),
    .rst(rst),
    .start(state == READ),
    .dividend(rd_data),
    .divisor(key_r),
    .quotient(q),
    .remainder(rem),
    .done(div_done)
  );
  always_comb begin
    nxt = state;
    accept = state == OUT && out_valid && out_ready;
    last = index == 4'(N_WORDS - 1);
    case (state)
      IDLE: nxt = start && key != '0 ? ADDR : IDLE;
      ADDR: nxt = READ;
      READ: nxt = DIV;
      DIV: nxt = div_done ? OUT : DIV;
      OUT: nxt = accept ? (last ? IDLE : ADDR) : OUT;
      default: nxt = IDLE;
    endcase
    rd_en = state == ADDR;
    rd_addr = rd_en ? N_WORDS'(1) << index : '0;
    busy = state != IDLE;
    num = rotr1(q[KEY_W-1:0]);
  end
  // the first OUT cycle loads the result registers; out_valid rises one cycle later
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
      index <= '0;
      key_r <= '0;
      out_valid <= 1'b0;
      out_index <= '0;
      out_num <= '0;
      out_err <= 1'b0;
      done <= 1'b0;
      div0 <= 1'b0;
    end else begin
      state <= nxt;
      done <= (state == IDLE && start && key == '0) || (accept && last);
      if (state == IDLE && start) begin
        key_r <= key;
        index <= '0;
        div0 <= key == '0;
      end
      if (state == OUT && !out_valid) begin
        out_valid <= 1'b1;
        out_index <= index;
        out_num <= num;
        out_err <= rem != '0 || q > DATA_W'(N_WORDS - 1) || num != index;
      end
      if (accept) begin
        out_valid <= 1'b0;
        if (!last) index <= index + 1'b1;
      end
    end
  end
endmodule

// File: tb/tb_product_reader.sv
// tb_product_reader: directed scans against a one-hot memory model with hand-computed results.
module tb_product_reader;
  logic clk = 0, rst = 1, start = 0, out_ready = 1;
  logic [3:0] key = 0;
  logic rd_en, out_valid, out_err, busy, done, div0;
  logic [15:0] rd_addr;
  logic [7:0] rd_data = 0;
  logic [3:0] out_index, out_num;
  logic [7:0] mem [16];
  logic [3:0] exp_num [16];
  logic exp_err [16];
  int n_assert = 0, n_fail = 0;

  product_reader dut (
    .clk(clk), .rst(rst), .start(start), .key(key), .rd_en(rd_en), .rd_addr(rd_addr),
    .rd_data(rd_data), .out_valid(out_valid), .out_ready(out_ready), .out_index(out_index),
    .out_num(out_num), .out_err(out_err), .busy(busy), .done(done), .div0(div0)
  );

  always #5 clk = ~clk;

  // read data appears one cycle after the strobe; filler otherwise exposes mistimed captures
  always @(posedge clk) begin
    rd_data <= 8'hA5;
    if (rd_en)
      for (int i = 0; i < 16; i++)
        if (rd_addr[i]) rd_data <= mem[i];
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic clear_mem();
    for (int i = 0; i < 16; i++) begin
      mem[i] = 8'd0;
      exp_num[i] = 4'd0;
      exp_err[i] = i != 0;
    end
  endtask

  task automatic start_scan(input logic [3:0] k);
    key = k;
    start = 1;
    tick();
    start = 0;
  endtask

  // entered with the DUT in ADDR for word 0; handles words 0..stop_idx-1
  task automatic collect(input int stall_idx, input int stop_idx);
    int k;
    logic [3:0] si, sn, sk;
    logic se;
    for (int i = 0; i < stop_idx; i++) begin
      chk($sformatf("rd_en[%0d]", i), rd_en, 1);
      chk($sformatf("rd_addr[%0d]", i), rd_addr, 32'(16'(1) << i));
      tick();
      chk($sformatf("rd_addr_drop[%0d]", i), {rd_en, rd_addr}, 0);
      k = 1;
      while (!out_valid && k < 40) begin
        tick();
        k++;
      end
      chk($sformatf("latency[%0d]", i), k, 11);
      if (!out_valid) return;
      chk($sformatf("out_index[%0d]", i), out_index, i);
      chk($sformatf("out_num[%0d]", i), out_num, exp_num[i]);
      chk($sformatf("out_err[%0d]", i), out_err, exp_err[i]);
      if (i == stall_idx) begin
        si = out_index; sn = out_num; se = out_err; sk = key;
        out_ready = 0;
        key = 0;
        start = 1;
        for (int s = 0; s < 5; s++) begin
          tick();
          start = 0;
          chk("stall_hold", {out_valid, out_index, out_num, out_err, rd_en}, {1'b1, si, sn, se, 1'b0});
          chk("stall_start_ignored", {div0, busy}, 2'b01);
        end
        key = sk;
        out_ready = 1;
      end
      tick();
      chk($sformatf("valid_fall[%0d]", i), out_valid, 0);
      chk($sformatf("done[%0d]", i), done, i == 15);
    end
  endtask

  initial begin
    clear_mem();
    repeat (3) tick();
    rst = 0;
    chk("reset_outputs", {busy, out_valid, rd_en, rd_addr, done, div0, out_index, out_num, out_err}, 0);
    tick();
    chk("idle_quiet", {busy, rd_en, done}, 0);

    // key 0: div0 and done together, no scan
    start_scan(4'd0);
    chk("div0_set", div0, 1);
    chk("div0_done", done, 1);
    chk("div0_idle", {busy, rd_en}, 0);

    // start coinciding with done; key 1 with write-path encoding of every index
    for (int i = 0; i < 16; i++) begin
      mem[i] = {4'b0000, 4'(i << 1) | 4'(i >> 3)};
      exp_num[i] = 4'(i);
      exp_err[i] = 0;
    end
    start_scan(4'd1);
    chk("div0_cleared", div0, 0);
    chk("busy_scan", busy, 1);
    collect(3, 16);
    chk("idle_after_scan", busy, 0);

    // key 8: word 8 exact, word 9 leaves remainder 1
    clear_mem();
    mem[8] = 8'd8; exp_num[8] = 4'b1000; exp_err[8] = 0;
    mem[9] = 8'd25; exp_num[9] = 4'b1001; exp_err[9] = 1;
    start_scan(4'd8);
    collect(-1, 16);

    // key 10: 90 decodes to 12; 98 leaves remainder 8 with quotient 9
    clear_mem();
    mem[12] = 8'd90; exp_num[12] = 4'b1100; exp_err[12] = 0;
    mem[11] = 8'd98; exp_num[11] = 4'b1100; exp_err[11] = 1;
    start_scan(4'd10);
    collect(-1, 16);

    // key 14: 98 decodes to 11; 224 gives quotient 16, 255 gives quotient 18 rem 3
    clear_mem();
    mem[11] = 8'd98; exp_num[11] = 4'b1011; exp_err[11] = 0;
    mem[0] = 8'd224; exp_num[0] = 4'b0000; exp_err[0] = 1;
    mem[5] = 8'd255; exp_num[5] = 4'b0001; exp_err[5] = 1;
    start_scan(4'd14);
    collect(-1, 16);

    // abort during division of word 6, then a clean rescan
    clear_mem();
    mem[8] = 8'd8; exp_num[8] = 4'b1000; exp_err[8] = 0;
    mem[9] = 8'd25; exp_num[9] = 4'b1001; exp_err[9] = 1;
    start_scan(4'd8);
    collect(-1, 6);
    repeat (3) tick();
    rst = 1;
    tick();
    rst = 0;
    chk("rst_abort", {busy, out_valid, rd_en, rd_addr, done}, 0);
    tick();
    chk("rst_stays_idle", {busy, rd_en}, 0);
    start_scan(4'd8);
    collect(-1, 16);
    tick();
    chk("done_pulse_end", {done, busy}, 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end
endmodule
